// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (if_*) and data (dm_*) requesters with a wait-cycle timeout; ports: clk, rst, if_req/if_addr/if_rdata/if_valid, dm_req/dm_we/dm_addr/dm_wdata/dm_rdata/dm_valid, mem_en/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready, stall_if, stall_mem, err; optional ARB_FETCH_GUARD_EN adds fetch-starvation guard
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IF_ACC = 2'd1;
  localparam logic [1:0] DM_ACC = 2'd2;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     cnt;
  logic              acc, tmo, done, guard, pick_dm, pick_if;
`ifdef ARB_FETCH_GUARD_EN
  logic [1:0] gcnt;
  // after three data wins over a waiting fetch, the fetch gets the next slot
  assign guard = if_req && gcnt == 2'd3;
  always_ff @(posedge clk or posedge rst)
    if (rst) gcnt <= 2'd0;
    else if (state == IDLE && pick_if) gcnt <= 2'd0;
    else if (state == IDLE && pick_dm && if_req) gcnt <= gcnt + 2'd1;
`else
  assign guard = 1'b0;
`endif
  assign pick_dm = dm_req && !guard;
  assign pick_if = if_req && !pick_dm;
  assign acc  = state != IDLE;
  assign tmo  = acc && cnt == CW'(TIMEOUT);
  assign done = acc && (mem_ready || tmo);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt     <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (pick_dm) begin
        state   <= DM_ACC;
        addr_q  <= dm_addr;
        we_q    <= dm_we;
        wdata_q <= dm_wdata;
      end else if (pick_if) begin
        state   <= IF_ACC;
        addr_q  <= if_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
      end
    end else if (done) state <= IDLE;
    else cnt <= cnt + CW'(1);
  assign mem_en    = acc;
  assign mem_we    = acc && we_q;
  assign mem_addr  = acc ? addr_q : '0;
  assign mem_wdata = acc ? wdata_q : '0;
  assign if_valid  = done && state == IF_ACC;
  assign dm_valid  = done && state == DM_ACC;
  // a timed-out access completes with zero data; mem_ready beats a coinciding timeout
  assign if_rdata  = (if_valid && mem_ready) ? mem_rdata : '0;
  assign dm_rdata  = (dm_valid && mem_ready) ? mem_rdata : '0;
  assign err       = tmo && !mem_ready;
  assign stall_if  = if_req && !if_valid;
  assign stall_mem = dm_req && !dm_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for priority, timeout, reset and fetch guard
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
  logic [7:0]  if_addr = '0, dm_addr = '0, mem_addr;
  logic [15:0] dm_wdata = '0, mem_rdata = '0, if_rdata, dm_rdata, mem_wdata;
  logic        if_valid, dm_valid, mem_en, mem_we, stall_if, stall_mem, err;
  int          n = 0, bad = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fetch;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        x_we;
    logic [15:0] x_wdata;
    logic        x_ifv, x_dmv;
    logic [15:0] x_ifr, x_dmr;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
  endtask

  logic exp_dm[4];

  initial begin
    vt[0] = '{1'b1, 1'b0, 8'h10, 16'hDEAD, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h0000};
    vt[1] = '{1'b0, 1'b0, 8'h33, 16'h7777, 16'hA5A5, 1'b0, 16'h7777, 1'b0, 1'b1, 16'h0000, 16'hA5A5};
    vt[2] = '{1'b0, 1'b1, 8'h20, 16'hBEEF, 16'h0F0F, 1'b1, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 16'h0F0F};
    vt[3] = '{1'b1, 1'b1, 8'hFF, 16'h5555, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h0000};
    vt[4] = '{1'b0, 1'b1, 8'h00, 16'h0001, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b1, 16'h0000, 16'h0000};
`ifdef ARB_FETCH_GUARD_EN
    exp_dm = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    // reset state: outputs zero, stalls follow inputs
    if_req = 1'b1; if_addr = 8'h99;
    #2;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_stall_if", stall_if, 1);
    chk("rst_stall_mem", stall_mem, 0);
    if_req = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    // table: single-requester accesses completing on the first ACC cycle
    foreach (vt[i]) begin
      if_req = vt[i].fetch; dm_req = !vt[i].fetch;
      if_addr = vt[i].addr; dm_addr = vt[i].addr;
      dm_we = vt[i].we; dm_wdata = vt[i].wdata; mem_rdata = vt[i].rdata; mem_ready = 1'b0;
      #1;
      chk("v_idle_en", mem_en, 0);
      tick;
      chk("v_en", mem_en, 1);
      chk("v_addr", mem_addr, vt[i].addr);
      chk("v_we", mem_we, vt[i].x_we);
      chk("v_wdata", mem_wdata, vt[i].x_wdata);
      chk("v_wait_valid", {if_valid, dm_valid}, 0);
      mem_ready = 1'b1;
      #1;
      chk("v_if_valid", if_valid, vt[i].x_ifv);
      chk("v_dm_valid", dm_valid, vt[i].x_dmv);
      chk("v_if_rdata", if_rdata, vt[i].x_ifr);
      chk("v_dm_rdata", dm_rdata, vt[i].x_dmr);
      chk("v_stalls", {stall_if, stall_mem}, 0);
      chk("v_err", err, 0);
      tick;
      idle_inputs;
      #1;
      chk("v_back_idle", mem_en, 0);
    end
    // data priority: write goes first, fetch stalls until served
    if_req = 1'b1; if_addr = 8'h44; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h20; dm_wdata = 16'hBEEF;
    mem_rdata = 16'h0101;
    tick;
    chk("pri_dm_we", mem_we, 1);
    chk("pri_dm_addr", mem_addr, 8'h20);
    chk("pri_dm_wdata", mem_wdata, 16'hBEEF);
    chk("pri_stall_if", stall_if, 1);
    mem_ready = 1'b1;
    #1;
    chk("pri_dm_valid", {dm_valid, if_valid, stall_mem, stall_if}, 4'b1001);
    tick;
    dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    #1;
    chk("pri_gap", {mem_en, stall_if}, 2'b01);
    tick;
    chk("pri_if_addr", mem_addr, 8'h44);
    chk("pri_if_we", mem_we, 0);
    chk("pri_if_stall", stall_if, 1);
    mem_ready = 1'b1; mem_rdata = 16'h4444;
    #1;
    chk("pri_if_valid", {if_valid, stall_if}, 2'b10);
    chk("pri_if_rdata", if_rdata, 16'h4444);
    tick;
    idle_inputs;
    tick;
    // timeout: 15 waited cycles, then valid with zero data and err pulse
    if_req = 1'b1; if_addr = 8'h55; mem_rdata = 16'hAAAA;
    tick;
    for (int k = 0; k < 15; k++) begin
      chk("to_wait", {if_valid, err, mem_en}, 3'b001);
      tick;
    end
    chk("to_valid", {if_valid, err}, 2'b11);
    chk("to_rdata", if_rdata, 0);
    tick;
    idle_inputs;
    #1;
    chk("to_after", {mem_en, err, if_valid}, 0);
    tick;
    // mem_ready coinciding with timeout wins
    dm_req = 1'b1; dm_addr = 8'h56; mem_rdata = 16'h5A5A;
    tick;
    for (int k = 0; k < 15; k++) tick;
    mem_ready = 1'b1;
    #1;
    chk("co_valid", {dm_valid, err}, 2'b10);
    chk("co_rdata", dm_rdata, 16'h5A5A);
    tick;
    idle_inputs;
    tick;
    // reset in the 3rd DM_ACC cycle drops the access asynchronously
    dm_req = 1'b1; dm_addr = 8'h66;
    tick; tick; tick;
    chk("rm_en_before", mem_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_en", mem_en, 0);
    chk("rm_valid_err", {dm_valid, err}, 0);
    chk("rm_addr", mem_addr, 0);
    dm_req = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("rm_idle", mem_en, 0);
    // both requesters held high: grant sequence
    if_req = 1'b1; dm_req = 1'b1; mem_ready = 1'b1; dm_addr = 8'h70; if_addr = 8'h71;
    for (int g = 0; g < 4; g++) begin
      tick;
      chk("grant_dm", dm_valid, exp_dm[g]);
      chk("grant_if", if_valid, !exp_dm[g]);
      tick;
    end
    idle_inputs;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
